// File: rtl/ml_ahb_master_input_stage_if.sv
// Bundles the master-side AHB bus, the per-slave-port request/grant lines and the data-phase owner.
// Latency: none, signal bundle only.
// Backpressure: none, signal bundle only.
// Ports: m_* from the AHB master, m_hreadyout/m_hresp back to it, s_* towards the slave-port arbiters,
//        s_grant/s_hready/s_hresp from the ports, dp_port to the external data muxes.
// Modport slave is the input stage's view; modport master is the view of the surrounding environment.
interface ml_ahb_master_input_stage_if #(
  parameter int NB_SLAVE_PORT = 4,
  parameter int ADDR_WIDTH    = 32
);
  logic [1:0]               m_htrans;
  logic [ADDR_WIDTH-1:0]    m_haddr;
  logic                     m_hwrite;
  logic [2:0]               m_hsize;
  logic [2:0]               m_hburst;
  logic [3:0]               m_hprot;
  logic [NB_SLAVE_PORT-1:0] m_dec_sel;
  logic                     m_hreadyout;
  logic                     m_hresp;
  logic [NB_SLAVE_PORT-1:0] s_sel;
  logic [1:0]               s_htrans;
  logic [ADDR_WIDTH-1:0]    s_haddr;
  logic                     s_hwrite;
  logic [2:0]               s_hsize;
  logic [2:0]               s_hburst;
  logic [3:0]               s_hprot;
  logic [NB_SLAVE_PORT-1:0] s_grant;
  logic [NB_SLAVE_PORT-1:0] s_hready;
  logic [NB_SLAVE_PORT-1:0] s_hresp;
  logic [NB_SLAVE_PORT-1:0] dp_port;

  modport slave (
    input  m_htrans, m_haddr, m_hwrite, m_hsize, m_hburst, m_hprot, m_dec_sel,
    input  s_grant, s_hready, s_hresp,
    output m_hreadyout, m_hresp,
    output s_sel, s_htrans, s_haddr, s_hwrite, s_hsize, s_hburst, s_hprot,
    output dp_port
  );

  modport master (
    output m_htrans, m_haddr, m_hwrite, m_hsize, m_hburst, m_hprot, m_dec_sel,
    output s_grant, s_hready, s_hresp,
    input  m_hreadyout, m_hresp,
    input  s_sel, s_htrans, s_haddr, s_hwrite, s_hsize, s_hburst, s_hprot,
    input  dp_port
  );
endinterface

// File: rtl/ml_ahb_master_input_stage.sv
// Master-side input stage of the multi-layer AHB matrix: forwards address phases, holds ungranted ones, tracks data phase.
// Latency: zero on the pass path (same-cycle sel/grant); hold path adds one stall cycle per cycle without port_ok.
// Backpressure: master is stalled via m_hreadyout while held, while the owning port is not ready, and in ERROR cycle 1.
// Ports: hclk/resetn (async active-low); bus = slave modport of ml_ahb_master_input_stage_if.
module ml_ahb_master_input_stage #(
  parameter int NB_SLAVE_PORT  = 4,
  parameter int PORT_IDX_WIDTH = 2,
  parameter int ADDR_WIDTH     = 32
) (
  input logic hclk,
  input logic resetn,
  ml_ahb_master_input_stage_if.slave bus
);

  typedef enum logic {A_PASS, A_HOLD} a_state_t;
  typedef enum logic [1:0] {DP_IDLE, DP_SLAVE, DP_ERR1, DP_ERR2} dp_state_t;

  a_state_t  a_state, a_next;
  dp_state_t dp_state, dp_next;

  logic [NB_SLAVE_PORT-1:0] dp_port, dp_port_next;

  // Held address phase. The decode is stored as a port index because it is one-hot by construction.
  logic [1:0]                h_htrans;
  logic [ADDR_WIDTH-1:0]     h_haddr;
  logic                      h_hwrite;
  logic [2:0]                h_hsize;
  logic [2:0]                h_hburst;
  logic [3:0]                h_hprot;
  logic [PORT_IDX_WIDTH-1:0] h_idx;
  logic [NB_SLAVE_PORT-1:0]  h_dec;
  logic [PORT_IDX_WIDTH-1:0] dec_idx;
  logic                      capture;

  logic [1:0]               src_htrans;
  logic [NB_SLAVE_PORT-1:0] src_dec;
  logic                     port_ok;
  logic                     valid_xfer;
  logic                     accept;
  logic                     hreadyout;
  logic                     hresp;

  always_comb begin
    dec_idx = '0;
    for (int i = 0; i < NB_SLAVE_PORT; i++) begin
      if (bus.m_dec_sel[i]) dec_idx = dec_idx | PORT_IDX_WIDTH'(i);
    end
  end

  always_comb begin
    h_dec        = '0;
    h_dec[h_idx] = 1'b1;
  end

  // Address source: the hold register while stalled, otherwise the live master bus.
  assign src_htrans    = (a_state == A_HOLD) ? h_htrans : bus.m_htrans;
  assign src_dec       = (a_state == A_HOLD) ? h_dec    : bus.m_dec_sel;
  assign bus.s_htrans  = src_htrans;
  assign bus.s_haddr   = (a_state == A_HOLD) ? h_haddr  : bus.m_haddr;
  assign bus.s_hwrite  = (a_state == A_HOLD) ? h_hwrite : bus.m_hwrite;
  assign bus.s_hsize   = (a_state == A_HOLD) ? h_hsize  : bus.m_hsize;
  assign bus.s_hburst  = (a_state == A_HOLD) ? h_hburst : bus.m_hburst;
  assign bus.s_hprot   = (a_state == A_HOLD) ? h_hprot  : bus.m_hprot;
  // BUSY still requests the port so the arbiter keeps its burst lock.
  assign bus.s_sel     = (src_htrans != 2'b00) ? src_dec : '0;

  assign port_ok    = |(src_dec & bus.s_grant & bus.s_hready);
  assign valid_xfer = bus.m_htrans[1];
  assign accept     = hreadyout & valid_xfer & (|bus.m_dec_sel);

  // Response to the master.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    if (a_state == A_HOLD) begin
      hreadyout = 1'b0;
    end else begin
      case (dp_state)
        DP_SLAVE: begin
          hreadyout = |(bus.s_hready & dp_port);
          hresp     = |(bus.s_hresp & dp_port);
        end
        DP_ERR1: begin
          hreadyout = 1'b0;
          hresp     = 1'b1;
        end
        DP_ERR2: begin
          hreadyout = 1'b1;
          hresp     = 1'b1;
        end
        default: begin
          hreadyout = 1'b1;
          hresp     = 1'b0;
        end
      endcase
    end
  end

  assign bus.m_hreadyout = hreadyout;
  assign bus.m_hresp     = hresp;
  assign bus.dp_port     = dp_port;

  // Next state for both FSMs; a data phase only opens when the address phase is granted.
  always_comb begin
    a_next       = a_state;
    dp_next      = dp_state;
    dp_port_next = dp_port;
    capture      = 1'b0;
    if (a_state == A_HOLD) begin
      if (port_ok) begin
        a_next       = A_PASS;
        dp_next      = DP_SLAVE;
        dp_port_next = h_dec;
      end
    end else if (hreadyout) begin
      dp_next      = DP_IDLE;
      dp_port_next = '0;
      if (accept) begin
        if (port_ok) begin
          dp_next      = DP_SLAVE;
          dp_port_next = bus.m_dec_sel;
        end else begin
          a_next  = A_HOLD;
          capture = 1'b1;
        end
      end else if (valid_xfer) begin
        dp_next = DP_ERR1;
      end
    end else if (dp_state == DP_ERR1) begin
      dp_next = DP_ERR2;
    end
  end

  always_ff @(posedge hclk or negedge resetn) begin
    if (!resetn) begin
      a_state  <= A_PASS;
      dp_state <= DP_IDLE;
      dp_port  <= '0;
      h_htrans <= '0;
      h_haddr  <= '0;
      h_hwrite <= 1'b0;
      h_hsize  <= '0;
      h_hburst <= '0;
      h_hprot  <= '0;
      h_idx    <= '0;
    end else begin
      a_state  <= a_next;
      dp_state <= dp_next;
      dp_port  <= dp_port_next;
      if (capture) begin
        h_htrans <= bus.m_htrans;
        h_haddr  <= bus.m_haddr;
        h_hwrite <= bus.m_hwrite;
        h_hsize  <= bus.m_hsize;
        h_hburst <= bus.m_hburst;
        h_hprot  <= bus.m_hprot;
        h_idx    <= dec_idx;
      end
    end
  end

endmodule

// File: tb/tb_ml_ahb_master_input_stage.sv
// Testbench for ml_ahb_master_input_stage: directed scenarios plus random traffic against a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ml_ahb_master_input_stage;

  logic hclk;
  logic resetn;

  ml_ahb_master_input_stage_if #(.NB_SLAVE_PORT(4), .ADDR_WIDTH(32)) bus ();

  ml_ahb_master_input_stage #(
    .NB_SLAVE_PORT(4), .PORT_IDX_WIDTH(2), .ADDR_WIDTH(32)
  ) dut (
    .hclk(hclk),
    .resetn(resetn),
    .bus(bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct packed {
    logic [1:0]  htrans;
    logic [31:0] addr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [3:0]  dec;
  } xfer_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of at most one stalled transfer, the data-phase owner
  // as a port number (-1 = none), and the number of ERROR cycles still to be shown.
  xfer_t held_q[$];
  int    owner;
  int    err_left;

  logic [3:0]  obs_sel, obs_dp;
  logic        obs_rdy, obs_resp;
  logic [31:0] obs_haddr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int port_of(input logic [3:0] d);
    int p = -1;
    for (int i = 0; i < 4; i++) if (d[i]) p = i;
    return p;
  endfunction

  task automatic model_reset();
    held_q.delete();
    owner    = -1;
    err_left = 0;
  endtask

  // One bus cycle: drive at negedge, check combinational outputs, then advance the model.
  task automatic step(input logic [1:0] t, input logic [3:0] d, input logic [3:0] g,
                      input logic [3:0] r, input logic [3:0] e, input logic [31:0] a);
    xfer_t      live, src;
    logic [3:0] exp_sel, exp_dp;
    logic       exp_rdy, exp_resp, ok;
    @(negedge hclk);
    live = '{htrans: t, addr: a, hwrite: 1'($urandom), hsize: 3'($urandom),
             hburst: 3'($urandom), hprot: 4'($urandom), dec: d};
    bus.m_htrans  = live.htrans;
    bus.m_haddr   = live.addr;
    bus.m_hwrite  = live.hwrite;
    bus.m_hsize   = live.hsize;
    bus.m_hburst  = live.hburst;
    bus.m_hprot   = live.hprot;
    bus.m_dec_sel = live.dec;
    bus.s_grant   = g;
    bus.s_hready  = r;
    bus.s_hresp   = e;
    #1;
    src     = (held_q.size() != 0) ? held_q[0] : live;
    exp_sel = (src.htrans != 2'b00) ? src.dec : 4'b0000;
    ok      = (src.dec & g & r) != 4'b0000;
    if (held_q.size() != 0)  begin exp_rdy = 1'b0; exp_resp = 1'b0; end
    else if (err_left == 2)  begin exp_rdy = 1'b0; exp_resp = 1'b1; end
    else if (err_left == 1)  begin exp_rdy = 1'b1; exp_resp = 1'b1; end
    else if (owner >= 0)     begin exp_rdy = r[owner]; exp_resp = e[owner]; end
    else                     begin exp_rdy = 1'b1; exp_resp = 1'b0; end
    exp_dp = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;

    chk("s_sel", 64'(bus.s_sel), 64'(exp_sel));
    chk("s_addr_ctrl", {bus.s_htrans, bus.s_haddr, bus.s_hwrite, bus.s_hsize, bus.s_hburst, bus.s_hprot},
        {src.htrans, src.addr, src.hwrite, src.hsize, src.hburst, src.hprot});
    chk("m_hreadyout", 64'(bus.m_hreadyout), 64'(exp_rdy));
    chk("m_hresp", 64'(bus.m_hresp), 64'(exp_resp));
    chk("dp_port", 64'(bus.dp_port), 64'(exp_dp));
    obs_sel   = bus.s_sel;
    obs_dp    = bus.dp_port;
    obs_rdy   = bus.m_hreadyout;
    obs_resp  = bus.m_hresp;
    obs_haddr = bus.s_haddr;

    if (held_q.size() != 0) begin
      if (ok) begin
        owner = port_of(held_q[0].dec);
        void'(held_q.pop_front());
      end
    end else if (exp_rdy) begin
      owner    = -1;
      err_left = 0;
      if (t[1]) begin
        if (d == 4'b0000) err_left = 2;
        else if (ok)      owner = port_of(d);
        else              held_q.push_back(live);
      end
    end else if (err_left == 2) begin
      err_left = 1;
    end
  endtask

  task automatic idle(input logic [3:0] g, input logic [3:0] r, input logic [3:0] e);
    step(2'b00, 4'b0000, g, r, e, 32'h0);
  endtask

  task automatic apply_reset();
    @(negedge hclk);
    resetn = 1'b0;
    #1;
    model_reset();
    chk("rst_hreadyout", 64'(bus.m_hreadyout), 64'd1);
    chk("rst_hresp", 64'(bus.m_hresp), 64'd0);
    chk("rst_s_sel", 64'(bus.s_sel), 64'd0);
    chk("rst_dp_port", 64'(bus.dp_port), 64'd0);
    @(negedge hclk);
    resetn = 1'b1;
  endtask

  initial begin
    int rdy_low, beats, beat;
    logic [3:0] hr_pat [8];
    resetn        = 1'b0;
    bus.m_htrans  = 2'b00;
    bus.m_haddr   = '0;
    bus.m_hwrite  = 1'b0;
    bus.m_hsize   = '0;
    bus.m_hburst  = '0;
    bus.m_hprot   = '0;
    bus.m_dec_sel = '0;
    bus.s_grant   = '0;
    bus.s_hready  = '1;
    bus.s_hresp   = '0;
    model_reset();
    apply_reset();

    // 1: granted NONSEQ to port 2, hreadyout follows s_hready[2]
    step(2'b10, 4'b0100, 4'b0100, 4'b1111, 4'b0000, 32'h0000_2000);
    chk("t1_sel", 64'(obs_sel), 64'h4);
    idle(4'b0000, 4'b1011, 4'b0000);
    chk("t1_dp", 64'(obs_dp), 64'h4);
    chk("t1_stall", 64'(obs_rdy), 64'd0);
    idle(4'b0000, 4'b1111, 4'b0000);
    chk("t1_done", 64'(obs_rdy), 64'd1);

    // 2: ungranted NONSEQ to port 1 is held; grant without hready still holds
    step(2'b10, 4'b0010, 4'b0000, 4'b1111, 4'b0000, 32'h1234_5678);
    idle(4'b0010, 4'b1101, 4'b0000);
    chk("t2_hold_rdy0", 64'(obs_rdy), 64'd0);
    chk("t2_hold_addr0", 64'(obs_haddr), 64'h1234_5678);
    for (int k = 1; k < 3; k++) begin
      idle(4'b0000, 4'b1111, 4'b0000);
      chk("t2_hold_rdy", 64'(obs_rdy), 64'd0);
      chk("t2_hold_addr", 64'(obs_haddr), 64'h1234_5678);
      chk("t2_hold_sel", 64'(obs_sel), 64'h2);
    end
    idle(4'b0010, 4'b1111, 4'b0000);
    idle(4'b0000, 4'b1111, 4'b0000);
    chk("t2_dp", 64'(obs_dp), 64'h2);

    // 3: unmapped NONSEQ gives the two-cycle ERROR and never selects a port
    step(2'b10, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 32'hdead_0000);
    chk("t3_sel", 64'(obs_sel), 64'h0);
    idle(4'b0000, 4'b1111, 4'b0000);
    chk("t3_err1", {obs_rdy, obs_resp}, 2'b01);
    idle(4'b0000, 4'b1111, 4'b0000);
    chk("t3_err2", {obs_rdy, obs_resp}, 2'b11);
    idle(4'b0000, 4'b1111, 4'b0000);
    chk("t3_after", {obs_rdy, obs_resp}, 2'b10);

    // 4: INCR4 to port 0 with s_hready[0] low for two cycles mid-burst
    hr_pat = '{4'hf, 4'hf, 4'he, 4'he, 4'hf, 4'hf, 4'hf, 4'hf};
    rdy_low = 0; beats = 0; beat = 0;
    for (int c = 0; c < 8; c++) begin
      if (beat < 4)
        step((beat == 0) ? 2'b10 : 2'b11, 4'b0001, 4'b0001, hr_pat[c], 4'b0000, 32'h100 + 32'(beat * 4));
      else
        idle(4'b0001, hr_pat[c], 4'b0000);
      if (!obs_rdy) rdy_low++;
      if (obs_rdy && obs_dp == 4'b0001) beats++;
      if (obs_rdy && beat < 4) beat++;
    end
    chk("t4_low_cycles", 64'(rdy_low), 64'd2);
    chk("t4_data_phases", 64'(beats), 64'd4);

    // 5: slave port 3 ERROR passes through
    step(2'b10, 4'b1000, 4'b1000, 4'b1111, 4'b0000, 32'h3000_0000);
    idle(4'b0000, 4'b0111, 4'b1000);
    chk("t5_err1", {obs_rdy, obs_resp}, 2'b01);
    idle(4'b0000, 4'b1111, 4'b1000);
    chk("t5_err2", {obs_rdy, obs_resp}, 2'b11);

    // 6: reset while holding drops the transfer
    step(2'b10, 4'b0100, 4'b0000, 4'b1111, 4'b0000, 32'h2222_0000);
    idle(4'b0000, 4'b1111, 4'b0000);
    chk("t6_in_hold", 64'(obs_rdy), 64'd0);
    apply_reset();
    idle(4'b0001, 4'b1111, 4'b0000);
    step(2'b10, 4'b0001, 4'b0001, 4'b1111, 4'b0000, 32'h0000_0040);
    chk("t6_sel", 64'(obs_sel), 64'h1);
    idle(4'b0000, 4'b1111, 4'b0000);
    chk("t6_dp", 64'(obs_dp), 64'h1);

    // Random traffic, every cycle checked against the model
    for (int n = 0; n < 2000; n++) begin
      logic [3:0] d, r, e;
      d = ($urandom_range(0, 4) == 0) ? 4'b0000 : (4'b0001 << $urandom_range(0, 3));
      r = 4'($urandom) | 4'($urandom);
      e = 4'($urandom) & 4'($urandom) & 4'($urandom);
      step(2'($urandom), d, 4'($urandom), r, e, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
